// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that borrows the execute-stage ALU to form the low WIDTH bits of op_a*op_b.
// Optional early termination when the remaining multiplier is zero: define MUL_SEQ_EARLY_TERM_EN.
module alu_mul_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] product,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [2:0]       ALU_ADD   = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;
  logic             load;
  logic             step;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and control decode; flush overrides everything
  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    load        = 1'b0;
    step        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = ~flush;
        if (start_valid) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        alu_a = acc;
        alu_b = mcand;
`ifdef MUL_SEQ_EARLY_TERM_EN
        if (mplier == '0) begin
          next_state = DONE;
        end else begin
          step = 1'b1;
          if (count == LAST_ITER) next_state = DONE;
        end
`else
        step = 1'b1;
        if (count == LAST_ITER) next_state = DONE;
`endif
      end
      DONE: begin
        busy       = 1'b1;
        done_valid = 1'b1;
        if (done_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (flush) begin
      next_state = IDLE;
      load       = 1'b0;
      step       = 1'b0;
    end
  end

  // Datapath: acc accumulates ALU sums for each set multiplier bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      count  <= '0;
    end else if (step) begin
      if (mplier[0]) acc <= alu_result;
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      count  <= count + CNT_W'(1);
    end
  end

  assign product = acc;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: transaction-level model plus per-cycle output comparison.
module tb_alu_mul_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         flush;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] product;
  logic         busy;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_control;
  logic [W-1:0] alu_result;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .flush(flush), .done_valid(done_valid),
    .done_ready(done_ready), .product(product), .busy(busy), .alu_a(alu_a),
    .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Stand-in for the execute-stage ALU (only add is exercised)
  assign alu_result = (alu_control == 3'b000) ? alu_a + alu_b : '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int run_cycles(input logic [W-1:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
    int msb;
    if (b == '0) return 1;
    msb = 0;
    for (int i = 0; i < int'(W); i++) if (b[i]) msb = i;
    return (msb + 2 > int'(W)) ? int'(W) : msb + 2;
`else
    return int'(W);
`endif
  endfunction

  // Transaction model: phase 0 idle, 1 run, 2 done
  int           m_phase;
  int           m_total;
  int           m_left;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic [W-1:0] m_prod;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_left  <= 0;
      m_total <= 0;
    end else if (flush) begin
      m_phase <= 0;
    end else begin
      case (m_phase)
        0: if (start_valid) begin
          m_phase <= 1;
          m_a     <= op_a;
          m_b     <= op_b;
          m_total <= run_cycles(op_b);
          m_left  <= run_cycles(op_b);
          m_prod  <= W'(64'(op_a) * 64'(op_b));
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_phase <= 2;
        end
        default: if (done_ready) m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      int k;
      logic [63:0] mask;
      chk("start_ready", 64'(start_ready), 64'(m_phase == 0 && !flush));
      chk("done_valid", 64'(done_valid), 64'(m_phase == 2));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("alu_control", 64'(alu_control), 64'd0);
      if (m_phase == 1) begin
        k    = m_total - m_left;
        mask = (64'd1 << k) - 64'd1;
        chk("alu_a_run", 64'(alu_a), 64'(W'(64'(m_a) * (64'(m_b) & mask))));
        chk("alu_b_run", 64'(alu_b), 64'(W'(64'(m_a) << k)));
      end else begin
        chk("alu_a_idle", 64'(alu_a), 64'd0);
        chk("alu_b_idle", 64'(alu_b), 64'd0);
      end
      if (m_phase == 2) chk("product", 64'(product), 64'(m_prod));
    end
  end

  task automatic check_reset_values();
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_alu_control", 64'(alu_control), 64'd0);
  endtask

  // Returns just after the accepting edge (+1)
  task automatic start_cmd(input logic [W-1:0] a, input logic [W-1:0] b);
    bit accepted;
    @(negedge clk); #2;
    start_valid = 1'b1;
    op_a = a;
    op_b = b;
    accepted = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (start_ready) accepted = 1'b1;
      @(posedge clk);
      if (accepted) break;
    end
    #1;
    start_valid = 1'b0;
    if (!accepted) chk("start_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        input bit pin, input logic [W-1:0] pin_val);
    int lat;
    start_cmd(a, b);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (done_valid) break;
    end
    chk("latency", 64'(lat), 64'(run_cycles(b)));
    if (pin) chk("product_pinned", 64'(product), 64'(pin_val));
    repeat (hold) @(posedge clk);
    #1;
    if (pin) chk("product_held", 64'(product), 64'(pin_val));
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("start_ready_after_done", 64'(start_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    start_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    flush = 1'b0;
    done_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_values();
    @(negedge clk); #2;
    reset = 1'b0;
    chk_en = 1'b1;

    do_mul(32'd7, 32'd6, 0, 1'b1, 32'd42);
`ifndef MUL_SEQ_EARLY_TERM_EN
    chk("fixed_latency_pin", 64'(run_cycles(32'd6)), 64'd32);
`endif
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'h0000_0001);
    do_mul(32'h8000_0000, 32'd2, 1, 1'b1, 32'h0000_0000);
    do_mul(32'd1234, 32'd5678, 10, 1'b1, 32'd7006652);

    // Flush mid-run with a competing start
    start_cmd(32'd100, 32'd200);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    start_valid = 1'b1;
    op_a = 32'd3;
    op_b = 32'd5;
    #1 chk("flush_blocks_start", 64'(start_ready), 64'd0);
    @(posedge clk); #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done_valid", 64'(done_valid), 64'd0);
    chk("flush_held_start_ready", 64'(start_ready), 64'd0);
    @(posedge clk); #1;
    chk("flush_idle_done_valid", 64'(done_valid), 64'd0);
    flush = 1'b0;
    start_valid = 1'b0;
    do_mul(32'd3, 32'd5, 0, 1'b1, 32'd15);

    // Asynchronous reset between edges while running
    start_cmd(32'd50, 32'd60);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_values();
    @(negedge clk); #2;
    reset = 1'b0;
    do_mul(32'd12, 32'd12, 0, 1'b1, 32'd144);

`ifdef MUL_SEQ_EARLY_TERM_EN
    do_mul(32'd77, 32'd0, 0, 1'b1, 32'd0);
    chk("et_zero_cycles", 64'(run_cycles(32'd0)), 64'd1);
    do_mul(32'd9, 32'd1, 0, 1'b1, 32'd9);
    chk("et_one_cycles", 64'(run_cycles(32'd1)), 64'd2);
    do_mul(32'd3, 32'h8000_0000, 0, 1'b1, 32'h8000_0000);
    chk("et_msb_cycles", 64'(run_cycles(32'h8000_0000)), 64'd32);
`endif

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = W'($urandom_range(0, 15));
        2: b = W'(1) << $urandom_range(0, 31);
        default: b = '0;
      endcase
      do_mul(a, b, int'($urandom_range(0, 3)), 1'b0, '0);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
